// File: rtl/trap_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// trap_sequencer_pkg
// Purpose : shared definitions for the machine-mode trap sequencer: datapath
//           width, CSR addresses, mstatus bit positions and the FSM state enum.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package trap_sequencer_pkg;

   localparam int XLEN = 32;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_E_MEPC   = 3'd1,
      ST_E_MCAUSE = 3'd2,
      ST_E_MSTAT  = 3'd3,
      ST_E_JUMP   = 3'd4,
      ST_R_MSTAT  = 3'd5,
      ST_R_JUMP   = 3'd6
   } state_t;

endpackage

// File: rtl/trap_sequencer_if.sv
// -----------------------------------------------------------------------------
// trap_sequencer_if
// Purpose : bundles the request, CSR-port and redirect signals of the trap
//           sequencer.
// Signals : i_ecall/i_mret     one-cycle request pulses (core -> sequencer)
//           i_pc/i_ecall_no    trapping PC and cause value
//           i_csr_rdata        CSR read data, combinational from o_csr_raddr
//           o_csr_raddr        CSR read address
//           o_csr_wr_en/waddr/wdata  single CSR write port
//           o_busy             stall for IFU/IDU
//           o_redirect/o_redirect_pc one-cycle PC redirect and its target
// Handshake: requests are single-cycle pulses with no ready signal; they are
//           taken only while the sequencer is idle, and o_busy (which rises
//           combinationally in the accept cycle) tells upstream to hold off.
// Modports: slave = sequencer side, master = core/CSR-file side.
// -----------------------------------------------------------------------------
interface trap_sequencer_if #(
   parameter int XLEN = trap_sequencer_pkg::XLEN
);
   logic            i_ecall;
   logic            i_mret;
   logic [XLEN-1:0] i_pc;
   logic [XLEN-1:0] i_ecall_no;
   logic [XLEN-1:0] i_csr_rdata;
   logic [11:0]     o_csr_raddr;
   logic            o_csr_wr_en;
   logic [11:0]     o_csr_waddr;
   logic [XLEN-1:0] o_csr_wdata;
   logic            o_busy;
   logic            o_redirect;
   logic [XLEN-1:0] o_redirect_pc;

   modport slave (
      input  i_ecall, i_mret, i_pc, i_ecall_no, i_csr_rdata,
      output o_csr_raddr, o_csr_wr_en, o_csr_waddr, o_csr_wdata,
      output o_busy, o_redirect, o_redirect_pc
   );

   modport master (
      output i_ecall, i_mret, i_pc, i_ecall_no, i_csr_rdata,
      input  o_csr_raddr, o_csr_wr_en, o_csr_waddr, o_csr_wdata,
      input  o_busy, o_redirect, o_redirect_pc
   );
endinterface

// File: rtl/trap_sequencer_mstatus_update.sv
// -----------------------------------------------------------------------------
// mstatus_update
// Purpose : combinational mstatus rewrite for trap entry and trap return.
// Ports   : i_old      current mstatus value
//           i_is_mret  0: trap entry (MPIE<=MIE, MIE<=0)
//                      1: trap return (MIE<=MPIE, MPIE<=1)
//           o_new      updated mstatus; MPP forced to M-mode in both cases,
//                      all other bits pass through untouched
// -----------------------------------------------------------------------------
module mstatus_update
   import trap_sequencer_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_old,
   input  logic            i_is_mret,
   output logic [XLEN-1:0] o_new
);

   always_comb begin
      o_new = i_old;
      if (i_is_mret) begin
         o_new[MSTATUS_MIE]  = i_old[MSTATUS_MPIE];
         o_new[MSTATUS_MPIE] = 1'b1;
      end else begin
         o_new[MSTATUS_MPIE] = i_old[MSTATUS_MIE];
         o_new[MSTATUS_MIE]  = 1'b0;
      end
      // M-only hart: previous privilege is always machine mode.
      o_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
   end

endmodule

// File: rtl/trap_sequencer.sv
// -----------------------------------------------------------------------------
// trap_sequencer
// Purpose : sequences machine-mode CSR updates for ecall (mepc, mcause,
//           mstatus, then redirect to mtvec) and mret (mstatus, then redirect
//           to mepc) over a single CSR write port, stalling the core meanwhile.
// Params  : XLEN         datapath width
//           MTVEC_ALIGN  1: clear mtvec[1:0] on redirect (direct mode)
// Ports   : clk, rst     clock, synchronous active-high reset
//           bus          trap_sequencer_if.slave (requests, CSR port, redirect)
//           o_state      current FSM state for observation
// -----------------------------------------------------------------------------
module trap_sequencer
   import trap_sequencer_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter bit MTVEC_ALIGN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   trap_sequencer_if.slave   bus,
   output state_t            o_state
);

   state_t          r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_cause;
   logic            r_wr_en;
   logic [11:0]     r_waddr;
   logic [11:0]     r_raddr;
   logic            r_redirect;

   logic [XLEN-1:0] w_mstatus_new;
   logic [XLEN-1:0] w_wdata;
   logic [XLEN-1:0] w_redirect_pc;
   logic            w_is_mret;

   assign w_is_mret = (r_state == ST_R_MSTAT);

   mstatus_update #(.XLEN(XLEN)) u_mstatus_update (
      .i_old     (bus.i_csr_rdata),
      .i_is_mret (w_is_mret),
      .o_new     (w_mstatus_new)
   );

   // Control outputs are registered: each transition loads the strobes and
   // addresses that belong to the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_pc       <= '0;
         r_cause    <= '0;
         r_wr_en    <= 1'b0;
         r_waddr    <= '0;
         r_raddr    <= '0;
         r_redirect <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.i_ecall) begin
                  // ecall has priority; a simultaneous mret is dropped.
                  r_pc       <= bus.i_pc;
                  r_cause    <= bus.i_ecall_no;
                  r_state    <= ST_E_MEPC;
                  r_wr_en    <= 1'b1;
                  r_waddr    <= CSR_MEPC;
                  r_raddr    <= '0;
                  r_redirect <= 1'b0;
               end else if (bus.i_mret) begin
                  r_state    <= ST_R_MSTAT;
                  r_wr_en    <= 1'b1;
                  r_waddr    <= CSR_MSTATUS;
                  r_raddr    <= CSR_MSTATUS;
                  r_redirect <= 1'b0;
               end else begin
                  r_wr_en    <= 1'b0;
                  r_waddr    <= '0;
                  r_raddr    <= '0;
                  r_redirect <= 1'b0;
               end
            end
            ST_E_MEPC: begin
               r_state <= ST_E_MCAUSE;
               r_wr_en <= 1'b1;
               r_waddr <= CSR_MCAUSE;
            end
            ST_E_MCAUSE: begin
               r_state <= ST_E_MSTAT;
               r_wr_en <= 1'b1;
               r_waddr <= CSR_MSTATUS;
               r_raddr <= CSR_MSTATUS;
            end
            ST_E_MSTAT: begin
               r_state    <= ST_E_JUMP;
               r_wr_en    <= 1'b0;
               r_waddr    <= '0;
               r_raddr    <= CSR_MTVEC;
               r_redirect <= 1'b1;
            end
            ST_R_MSTAT: begin
               r_state    <= ST_R_JUMP;
               r_wr_en    <= 1'b0;
               r_waddr    <= '0;
               r_raddr    <= CSR_MEPC;
               r_redirect <= 1'b1;
            end
            default: begin
               // ST_E_JUMP, ST_R_JUMP and any unused encoding return to idle.
               r_state    <= ST_IDLE;
               r_wr_en    <= 1'b0;
               r_waddr    <= '0;
               r_raddr    <= '0;
               r_redirect <= 1'b0;
            end
         endcase
      end
   end

   // Write data: mepc/mcause come from the latched request, mstatus is a
   // same-cycle read-modify-write through the combinational read port.
   always_comb begin
      w_wdata = '0;
      case (r_state)
         ST_E_MEPC:   w_wdata = r_pc;
         ST_E_MCAUSE: w_wdata = r_cause;
         ST_E_MSTAT:  w_wdata = w_mstatus_new;
         ST_R_MSTAT:  w_wdata = w_mstatus_new;
         default:     w_wdata = '0;
      endcase
   end

   // Redirect target is taken straight from the CSR read (mtvec or mepc).
   always_comb begin
      w_redirect_pc = '0;
      if (r_redirect) begin
         if (r_state == ST_E_JUMP && MTVEC_ALIGN)
            w_redirect_pc = {bus.i_csr_rdata[XLEN-1:2], 2'b00};
         else
            w_redirect_pc = bus.i_csr_rdata;
      end
   end

   assign bus.o_csr_raddr   = r_raddr;
   assign bus.o_csr_wr_en   = r_wr_en;
   assign bus.o_csr_waddr   = r_waddr;
   assign bus.o_csr_wdata   = w_wdata;
   assign bus.o_redirect    = r_redirect;
   assign bus.o_redirect_pc = w_redirect_pc;
   // Busy rises in the accept cycle so the core stalls without a bubble.
   assign bus.o_busy        = (r_state != ST_IDLE) | bus.i_ecall | bus.i_mret;
   assign o_state           = r_state;

endmodule

// File: tb/tb_trap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_trap_sequencer
// Purpose : self-checking bench for trap_sequencer. Two instances share one
//           CSR file model: dut (MTVEC_ALIGN=1) owns the writes, dut_raw
//           (MTVEC_ALIGN=0) mirrors its inputs so the unaligned redirect
//           target can be observed alongside.
// -----------------------------------------------------------------------------
module tb_trap_sequencer;
   import trap_sequencer_pkg::*;

   // Expected cycle record: {we, waddr, wdata, redirect, rpc, rpc_raw, busy}
   localparam int W = 111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   trap_sequencer_if #(.XLEN(32)) bus ();
   trap_sequencer_if #(.XLEN(32)) bus2 ();
   state_t st;
   state_t st2;

   trap_sequencer #(.XLEN(32), .MTVEC_ALIGN(1'b1)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.slave),
      .o_state (st)
   );

   trap_sequencer #(.XLEN(32), .MTVEC_ALIGN(1'b0)) dut_raw (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus2.slave),
      .o_state (st2)
   );

   // CSR file environment: combinational read, write on clock edge.
   logic [31:0] csr_mem [0:4095];
   logic        poke_en = 1'b0;
   logic [11:0] poke_addr = '0;
   logic [31:0] poke_data = '0;

   assign bus.i_csr_rdata  = csr_mem[bus.o_csr_raddr];
   assign bus2.i_csr_rdata = csr_mem[bus2.o_csr_raddr];
   assign bus2.i_ecall     = bus.i_ecall;
   assign bus2.i_mret      = bus.i_mret;
   assign bus2.i_pc        = bus.i_pc;
   assign bus2.i_ecall_no  = bus.i_ecall_no;

   always @(posedge clk) begin
      if (poke_en)
         csr_mem[poke_addr] <= poke_data;
      else if (bus.o_csr_wr_en)
         csr_mem[bus.o_csr_waddr] <= bus.o_csr_wdata;
   end

   // Scoreboard and reference model state
   logic [W-1:0] exp_q[$];
   int           n_cmp = 0;
   int           n_fail = 0;
   logic         allow_overlap = 1'b0;
   logic [31:0]  mdl_mepc, mdl_mcause, mdl_mstatus, mdl_mtvec;

   // Architectural mstatus effects written as plain bit arithmetic.
   function automatic logic [31:0] f_entry(input logic [31:0] s);
      logic [31:0] mie;
      mie = (s >> 3) & 32'h1;
      return (s & ~32'h0000_1888) | (mie << 7) | 32'h0000_1800;
   endfunction

   function automatic logic [31:0] f_return(input logic [31:0] s);
      logic [31:0] mpie;
      mpie = (s >> 7) & 32'h1;
      return (s & ~32'h0000_1888) | (mpie << 3) | 32'h0000_1880;
   endfunction

   function automatic logic [W-1:0] mk(input logic we, input logic [11:0] wa,
                                       input logic [31:0] wd, input logic rd,
                                       input logic [31:0] rpc, input logic [31:0] rpc_raw,
                                       input logic busy);
      return {we, wa, wd, rd, rpc, rpc_raw, busy};
   endfunction

   task automatic cmp32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic check_rec(input logic [W-1:0] e, input string tag);
      logic [W-1:0] obs;
      obs = {bus.o_csr_wr_en,
             e[110] ? bus.o_csr_waddr : 12'h0,
             e[110] ? bus.o_csr_wdata : 32'h0,
             bus.o_redirect,
             e[65] ? bus.o_redirect_pc : 32'h0,
             e[65] ? bus2.o_redirect_pc : 32'h0,
             bus.o_busy};
      n_cmp++;
      assert (obs === e) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
      // Upstream must not request while a sequence is in flight.
      n_cmp++;
      assert (allow_overlap || st == ST_IDLE || !(bus.i_ecall || bus.i_mret)) else begin
         n_fail++;
         $error("FAIL %s_protocol: observed request in state %0d expected none", tag, st);
      end
   endtask

   task automatic check_all_zero(input string tag);
      logic [110:0] obs;
      obs = {bus.o_csr_wr_en, bus.o_csr_waddr, bus.o_csr_raddr, bus.o_csr_wdata,
             bus.o_redirect, bus.o_redirect_pc, bus.o_busy};
      n_cmp++;
      assert (obs === 111'h0 && st == ST_IDLE) else begin
         n_fail++;
         $error("FAIL %s: observed %h state %0d expected all zero in IDLE", tag, obs, st);
      end
   endtask

   task automatic set_csr(input logic [11:0] a, input logic [31:0] d);
      poke_en   = 1'b1;
      poke_addr = a;
      poke_data = d;
      @(negedge clk);
      poke_en   = 1'b0;
      case (a)
         CSR_MEPC:    mdl_mepc    = d;
         CSR_MCAUSE:  mdl_mcause  = d;
         CSR_MSTATUS: mdl_mstatus = d;
         CSR_MTVEC:   mdl_mtvec   = d;
         default: ;
      endcase
   endtask

   // Runs one request from an idle negedge. pulse_at: cycle index in which a
   // stray ecall is pulsed; rst_at: cycle index after which rst is raised.
   task automatic run_txn(input logic e, input logic m, input logic [31:0] pc,
                          input logic [31:0] cause, input int pulse_at,
                          input int rst_at, input string tag);
      logic [W-1:0] r;
      int idx;
      exp_q.delete();
      if (e) begin
         exp_q.push_back(mk(1'b1, CSR_MEPC, pc, 1'b0, 32'h0, 32'h0, 1'b1));
         exp_q.push_back(mk(1'b1, CSR_MCAUSE, cause, 1'b0, 32'h0, 32'h0, 1'b1));
         exp_q.push_back(mk(1'b1, CSR_MSTATUS, f_entry(mdl_mstatus), 1'b0, 32'h0, 32'h0, 1'b1));
         exp_q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b1, mdl_mtvec & ~32'h3, mdl_mtvec, 1'b1));
      end else if (m) begin
         exp_q.push_back(mk(1'b1, CSR_MSTATUS, f_return(mdl_mstatus), 1'b0, 32'h0, 32'h0, 1'b1));
         exp_q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b1, mdl_mepc, mdl_mepc, 1'b1));
      end
      bus.i_ecall    = e;
      bus.i_mret     = m;
      bus.i_pc       = pc;
      bus.i_ecall_no = cause;
      #1;
      n_cmp++;
      assert (bus.o_busy === (e | m)) else begin
         n_fail++;
         $error("FAIL %s_accept_busy: observed %b expected %b", tag, bus.o_busy, e | m);
      end
      idx = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         idx++;
         bus.i_ecall   = 1'b0;
         bus.i_mret    = 1'b0;
         allow_overlap = 1'b0;
         if (idx == pulse_at) begin
            allow_overlap  = 1'b1;
            bus.i_ecall    = 1'b1;
            bus.i_pc       = $urandom;
            bus.i_ecall_no = $urandom;
         end
         #1;
         r = exp_q.pop_front();
         check_rec(r, $sformatf("%s_c%0d", tag, idx));
         if (r[110]) begin
            case (r[109:98])
               CSR_MEPC:    mdl_mepc    = r[97:66];
               CSR_MCAUSE:  mdl_mcause  = r[97:66];
               CSR_MSTATUS: mdl_mstatus = r[97:66];
               default: ;
            endcase
         end
         if (idx == rst_at) begin
            rst = 1'b1;
            exp_q.delete();
         end
      end
      @(negedge clk);
      bus.i_ecall   = 1'b0;
      bus.i_mret    = 1'b0;
      allow_overlap = 1'b0;
      rst           = 1'b0;
      #1;
      if (rst_at > 0)
         check_all_zero({tag, "_after_rst"});
      else
         check_rec(mk(1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0), {tag, "_idle"});
      cmp32({tag, "_mepc"},    csr_mem[CSR_MEPC],    mdl_mepc);
      cmp32({tag, "_mcause"},  csr_mem[CSR_MCAUSE],  mdl_mcause);
      cmp32({tag, "_mstatus"}, csr_mem[CSR_MSTATUS], mdl_mstatus);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: observed no completion expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int kind;
      bus.i_ecall    = 1'b0;
      bus.i_mret     = 1'b0;
      bus.i_pc       = '0;
      bus.i_ecall_no = '0;

      // Reset
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      set_csr(CSR_MEPC, 32'h0);
      set_csr(CSR_MCAUSE, 32'h0);
      set_csr(CSR_MTVEC, 32'h8000_0800);
      set_csr(CSR_MSTATUS, 32'h0000_1808);

      // Directed ecall
      run_txn(1'b1, 1'b0, 32'h8000_0100, 32'hB, 0, 0, "ecall_dir");
      cmp32("ecall_dir_mstatus_const", csr_mem[CSR_MSTATUS], 32'h0000_1880);

      // Directed mret
      set_csr(CSR_MEPC, 32'h8000_0104);
      run_txn(1'b0, 1'b1, 32'h0, 32'h0, 0, 0, "mret_dir");
      cmp32("mret_dir_mstatus_const", csr_mem[CSR_MSTATUS], 32'h0000_1888);

      // ecall and mret together: ecall only
      set_csr(CSR_MSTATUS, 32'h0000_1808);
      run_txn(1'b1, 1'b1, 32'h8000_0200, 32'h8, 0, 0, "both");
      cmp32("both_mstatus_const", csr_mem[CSR_MSTATUS], 32'h0000_1880);

      // Misaligned mtvec: aligned on dut, raw on dut_raw
      set_csr(CSR_MTVEC, 32'h8000_0801);
      run_txn(1'b1, 1'b0, 32'h8000_0300, 32'h3, 0, 0, "mtvec_align");

      // Reset during E_MCAUSE
      set_csr(CSR_MSTATUS, 32'h0000_0008);
      run_txn(1'b1, 1'b0, 32'h8000_0400, 32'h5, 0, 2, "rst_mid");
      cmp32("rst_mid_mepc_const", csr_mem[CSR_MEPC], 32'h8000_0400);
      cmp32("rst_mid_mstatus_const", csr_mem[CSR_MSTATUS], 32'h0000_0008);

      // Back-to-back: stray ecall in E_MEPC ignored, next-cycle ecall accepted
      run_txn(1'b1, 1'b0, 32'h8000_0500, 32'hB, 1, 0, "b2b");
      run_txn(1'b1, 1'b0, 32'h8000_0600, 32'h9, 0, 0, "b2b_next");

      // Randomized requests against the model
      for (int i = 0; i < 12; i++) begin
         set_csr(CSR_MSTATUS, $urandom);
         set_csr(CSR_MTVEC, $urandom);
         set_csr(CSR_MEPC, $urandom);
         kind = $urandom_range(0, 2);
         run_txn(kind != 1, kind != 0, $urandom, $urandom, 0, 0,
                 $sformatf("rnd%0d_k%0d", i, kind));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
